// File: rtl/tmr0_pkg.sv
// tmr0_pkg: SFR addresses, OPTION/INTCON bit indices, reset values and prescaler mask helper
package tmr0_pkg;
  localparam logic [7:0] ADDR_TMR0   = 8'h01;
  localparam logic [7:0] ADDR_OPTION = 8'h81;
  localparam logic [7:0] ADDR_INTCON = 8'h0B;
  localparam int OPT_T0CS = 5;
  localparam int OPT_T0SE = 4;
  localparam int OPT_PSA  = 3;
  localparam int INT_GIE  = 7;
  localparam int INT_T0IE = 5;
  localparam int INT_T0IF = 2;
  localparam logic [7:0] OPTION_RST = 8'hFF;
  localparam logic [7:0] INTCON_RST = 8'h00;
  function automatic logic [7:0] ps_mask(input logic [2:0] ps);
    return 8'((9'd2 << ps) - 9'd1);
  endfunction
endpackage

// File: rtl/tmr0_prescaler.sv
// tmr0_prescaler: 8-bit event divider (ev in, clr, psa bypass, ps ratio select) producing the TMR0 increment pulse inc
module tmr0_prescaler import tmr0_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev,
  input  logic       clr,
  input  logic       psa,
  input  logic [2:0] ps,
  output logic       inc
);
  logic [7:0] cnt;
  logic match;
  assign match = cnt == ps_mask(ps);
  assign inc = ev & (psa | match);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || psa) cnt <= '0;
    else if (ev) cnt <= match ? 8'h00 : cnt + 8'h01;
endmodule

// File: rtl/tmr0_ctrl.sv
// tmr0_ctrl: TMR0/OPTION/INTCON sequencer; oscIn/mclr_n clock+async reset, t0cki pin, sfr_* bus, tmr0_q/option_q/t0if/irq status
module tmr0_ctrl import tmr0_pkg::*; #(
  parameter int Q_DIV       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int INHIBIT_TCY = 2
) (
  input  logic       oscIn,
  input  logic       mclr_n,
  input  logic       t0cki,
  input  logic [7:0] sfr_addr,
  input  logic [7:0] sfr_wdata,
  input  logic       sfr_we,
  input  logic       sfr_re,
  output logic [7:0] sfr_rdata,
  output logic       sfr_rvalid,
  output logic [7:0] tmr0_q,
  output logic [7:0] option_q,
  output logic       t0if,
  output logic       irq
);
  localparam int QW = $clog2(Q_DIV);
  logic [QW-1:0] q;
  logic [SYNC_STAGES-1:0] sync;
  logic hist, gie, t0ie, tick, ext_ev, src_ev, inc, ovf;
  logic wr_tmr, wr_opt, wr_int, opt_chg;
  logic [7:0] inhibit, rd_val;
  assign tick    = q == QW'(Q_DIV - 1);
  assign wr_tmr  = sfr_we && sfr_addr == ADDR_TMR0;
  assign wr_opt  = sfr_we && sfr_addr == ADDR_OPTION;
  assign wr_int  = sfr_we && sfr_addr == ADDR_INTCON;
  assign opt_chg = wr_opt && sfr_wdata[3:0] != option_q[3:0];
  assign ext_ev  = option_q[OPT_T0SE] ? hist & ~sync[SYNC_STAGES-1] : sync[SYNC_STAGES-1] & ~hist;
  assign src_ev  = option_q[OPT_T0CS] ? ext_ev : tick;
  assign ovf     = inc && !wr_tmr && tmr0_q == 8'hFF;
  assign irq     = gie & t0ie & t0if;
  assign rd_val  = sfr_addr == ADDR_TMR0   ? tmr0_q :
                   sfr_addr == ADDR_OPTION ? option_q :
                   sfr_addr == ADDR_INTCON ? {gie, 1'b0, t0ie, 2'b00, t0if, 2'b00} : 8'h00;
  tmr0_prescaler u_pre (
    .clk  (oscIn),
    .rst_n(mclr_n),
    .ev   (src_ev && inhibit == 8'h00),
    .clr  (wr_tmr | opt_chg),
    .psa  (option_q[OPT_PSA]),
    .ps   (option_q[2:0]),
    .inc  (inc)
  );
  always_ff @(posedge oscIn or negedge mclr_n)
    if (!mclr_n) begin
      q          <= '0;
      sync       <= '0;
      hist       <= 1'b0;
      inhibit    <= 8'h00;
      tmr0_q     <= 8'h00;
      option_q   <= OPTION_RST;
      gie        <= INTCON_RST[INT_GIE];
      t0ie       <= INTCON_RST[INT_T0IE];
      t0if       <= INTCON_RST[INT_T0IF];
      sfr_rdata  <= 8'h00;
      sfr_rvalid <= 1'b0;
    end else begin
      q          <= q + 1'b1;
      sync       <= {sync[SYNC_STAGES-2:0], t0cki};
      hist       <= sync[SYNC_STAGES-1];
      inhibit    <= wr_tmr ? 8'(INHIBIT_TCY) : tick && inhibit != 8'h00 ? inhibit - 8'h01 : inhibit;
      tmr0_q     <= wr_tmr ? sfr_wdata : inc ? tmr0_q + 8'h01 : tmr0_q;
      option_q   <= wr_opt ? sfr_wdata : option_q;
      gie        <= wr_int ? sfr_wdata[INT_GIE] : gie;
      t0ie       <= wr_int ? sfr_wdata[INT_T0IE] : t0ie;
      t0if       <= ovf | (wr_int ? sfr_wdata[INT_T0IF] : t0if);
      sfr_rdata  <= sfr_re ? rd_val : sfr_rdata;
      sfr_rvalid <= sfr_re;
    end
endmodule

// File: doc/tmr0_ctrl.md
Name: tmr0_ctrl

Overview:
Single-clock TMR0 sequencer and SFR front-end for the PIC16F84A-style timer. It owns the TMR0, OPTION_REG and INTCON (timer bits) registers and derives the instruction-cycle tick (Tcy = oscIn/4). It synchronises T0CKI, applies edge select, prescaler, PSA routing and write-inhibit, and raises T0IF and irq. It replaces multi-clock timer logic with one clock domain driven from the CPU's SFR bus.

Parameters:
- Q_DIV, 4, oscIn cycles per instruction cycle (power of 2, ≥2)
- SYNC_STAGES, 2, T0CKI synchroniser depth (≥2)
- INHIBIT_TCY, 2, Tcy ticks of increment suppression after a TMR0 write

Ports:
- oscIn  in  1  system clock, all flops on rising edge
- mclr_n  in  1  asynchronous active-low reset
- t0cki  in  1  external timer clock pin (asynchronous)
- sfr_addr  in  8  SFR address: 0x01 TMR0, 0x81 OPTION_REG, 0x0B INTCON
- sfr_wdata  in  8  write data
- sfr_we  in  1  write strobe, one oscIn cycle
- sfr_re  in  1  read strobe, one oscIn cycle
- sfr_rdata  out  8  read data
- sfr_rvalid  out  1  read data valid
- tmr0_q  out  8  current TMR0 value
- option_q  out  8  current OPTION_REG
- t0if  out  1  TMR0 overflow flag (INTCON bit 2)
- irq  out  1  GIE & T0IE & T0IF

Behaviour:
- Reset (mclr_n low, async): TMR0=0x00, OPTION=0xFF, INTCON timer bits (GIE b7, T0IE b5, T0IF b2)=0, q counter=0, prescaler=0, inhibit=0, sync flops=0, sfr_rdata=0x00, sfr_rvalid=0. Release mid-operation restarts all counting from these values.
- Tcy tick: q counter 0..Q_DIV-1, wraps; tick is 1 for the cycle where q==Q_DIV-1.
- OPTION fields: T0CS b5, T0SE b4, PSA b3, PS b2:0; b7:6 stored, unused.
- Source event: T0CS=0 gives the Tcy tick. T0CS=1: t0cki passes through SYNC_STAGES flops plus one history flop; rising edge (T0SE=0) or falling edge (T0SE=1) of the synchronised signal yields a one-cycle event. TMR0 changes on the 3rd oscIn edge after t0cki toggles (default depth). Pulses shorter than 2 oscIn high or low need not be counted.
- Prescaler, PSA=0: 8-bit counter advances on each source event. The increment fires on the event where counter == 2^(PS+1)-1, then the counter returns to 0. Ratio is 1:2..1:256.
- Prescaler, PSA=1: every source event increments; prescaler held at 0.
- Increment: TMR0 <= TMR0+1 mod 256. 0xFF->0x00 sets T0IF in the same cycle.
- Inhibit: a TMR0 write loads sfr_wdata, clears the prescaler and sets inhibit=INHIBIT_TCY. Each Tcy tick decrements inhibit while it is nonzero. Increments are discarded while inhibit!=0; the prescaler also does not advance.
- An OPTION write clears the prescaler when PSA or PS changes.
- Write vs increment in the same cycle: the write wins and the increment is lost.
- An INTCON write updates GIE, T0IE and T0IF from sfr_wdata. If an overflow occurs in the same cycle, T0IF=1 (set wins). Other INTCON bits are not owned here: they read 0 and writes to them are ignored.
- Read: one-cycle latency. The cycle after sfr_re, sfr_rvalid=1 and sfr_rdata holds the register value from the sfr_re cycle. An unmapped address returns 0x00 with rvalid=1. sfr_rdata holds its value when rvalid=0.
- Simultaneous sfr_we and sfr_re to the same address: the read returns the pre-write value.
- irq is combinational from registered bits.

Decomposition:
- Package tmr0_pkg: address constants (ADDR_TMR0, ADDR_OPTION, ADDR_INTCON), OPTION/INTCON bit indices, reset values (OPTION_RST=0xFF, INTCON_RST=0x00).
- Sub-module tmr0_prescaler: 8-bit counter, PS match, PSA bypass, clear input. Inputs are event and clear; output is the increment pulse.

Test Plan:
- Reset: assert mclr_n mid-count -> tmr0_q=0x00, option_q=0xFF, t0if=0, irq=0 immediately; counting restarts from q=0 after release.
- Internal, 1:1: write OPTION=0xC8, then TMR0=0xFE -> no change for 2 Tcy; 0xFF after 3rd tick; 0x00 with t0if=1 on 4th tick.
- Prescaler: OPTION=0xC1 (1:4), TMR0=0x00 -> after inhibit, increments every 16 oscIn. Changing PS mid-count to 000 clears the prescaler; the next increment follows 2 Tcy later.
- External: OPTION=0xE8, t0cki rising edges 8 oscIn apart -> +1 per edge, 3 oscIn latency. Set T0SE=1 (0xF8) -> falling edges count instead.
- Interrupt: INTCON=0xA0, overflow -> t0if=1, irq=1. Writing INTCON=0xA0 clears the flag. Clear coincident with overflow -> t0if stays 1.
- Bus: read 0x01, 0x81, 0x0B and 0x55 -> correct values next cycle with rvalid=1; 0x55 returns 0x00. Same-cycle TMR0 write and increment -> write value held.
